// File: rtl/ram_bus_sync.sv
// Synchronous single-port RAM with req/ack handshake, programmable wait states and zero-fill after reset.
// Define RAM_RANGE_CHK_EN to add the err port that flags out-of-range accesses.
module ram_bus_sync #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              ready
`ifdef RAM_RANGE_CHK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_cnt;
  logic [3:0]        wait_cnt;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_in_range;
  logic              do_access;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST_IDX) state_nxt = IDLE;
      IDLE:    if (req) state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use the live inputs there.
  always_comb begin
    acc_we    = we_l;
    acc_addr  = addr_l;
    acc_wdata = wdata_l;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
  assign do_access    = (state_nxt == RESP) && (state != RESP);
  assign mem_we       = (state == CLEAR) || (do_access && acc_we && acc_in_range);
  assign mem_addr     = (state == CLEAR) ? clr_cnt[ADDR_W-1:0] : acc_addr;
  assign mem_din      = (state == CLEAR) ? '0 : acc_wdata;

  // ack and ready decode straight from state, so an asynchronous reset drops them immediately.
  assign ack   = (state == RESP);
  assign ready = (state != CLEAR);

`ifdef RAM_RANGE_CHK_EN
  assign err = (state == RESP) && ({1'b0, addr_l} >= DEPTH_W);
`endif

  // NOTE: the storage array has no reset branch; the CLEAR sweep zeroes it so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_cnt  <= '0;
      wait_cnt <= '0;
      we_l     <= 1'b0;
      addr_l   <= '0;
      wdata_l  <= '0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == IDLE && req) begin
        we_l     <= we;
        addr_l   <= addr;
        wdata_l  <= wdata;
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (do_access && !acc_we) rdata <= acc_in_range ? mem[acc_addr] : '0;
    end
  end

endmodule

// File: tb/tb_ram_bus_sync.sv
// Bench for ram_bus_sync: three instances (0 and 3 wait states at full depth, 1 wait state at DEPTH=1000)
// checked every cycle against a transaction-level model plus directed literal expectations.
module tb_ram_bus_sync;

  localparam int N       = 3;
  localparam int WS_T [N] = '{0, 3, 1};
  localparam int DP_T [N] = '{1024, 1024, 1000};
  localparam int LIMIT   = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        req   [N];
  logic        we    [N];
  logic [9:0]  addr  [N];
  logic [15:0] wdata [N];
  logic [15:0] rdata [N];
  logic        ack   [N];
  logic        ready [N];
`ifdef RAM_RANGE_CHK_EN
  logic        err   [N];
`endif

  int total = 0;
  int bad   = 0;

  ram_bus_sync #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ack(ack[0]), .ready(ready[0])
`ifdef RAM_RANGE_CHK_EN
    , .err(err[0])
`endif
  );

  ram_bus_sync #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ack(ack[1]), .ready(ready[1])
`ifdef RAM_RANGE_CHK_EN
    , .err(err[1])
`endif
  );

  ram_bus_sync #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .WAIT_STATES(1)) u_d1000 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .ack(ack[2]), .ready(ready[2])
`ifdef RAM_RANGE_CHK_EN
    , .err(err[2])
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: memory contents, remaining clear cycles and the pending transaction per instance.
  bit [15:0] mm [N][1024];
  int        clr_left [N];
  bit        pend     [N];
  int        rem      [N];
  bit        m_ack    [N];
  bit        m_err    [N];
  bit [15:0] m_rdata  [N];
  bit        p_we     [N];
  bit [9:0]  p_a      [N];
  bit [15:0] p_d      [N];

  task automatic complete(input int g, input bit w, input bit [9:0] a, input bit [15:0] d);
    m_ack[g] <= 1'b1;
    m_err[g] <= (int'(a) >= DP_T[g]);
    if (w) begin
      if (int'(a) < DP_T[g]) mm[g][a] <= d;
    end else begin
      m_rdata[g] <= (int'(a) < DP_T[g]) ? mm[g][a] : 16'h0000;
    end
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rst[g]) begin
        clr_left[g] <= DP_T[g];
        pend[g]     <= 1'b0;
        rem[g]      <= 0;
        m_ack[g]    <= 1'b0;
        m_err[g]    <= 1'b0;
        m_rdata[g]  <= 16'h0000;
        for (int k = 0; k < 1024; k++) mm[g][k] <= 16'h0000;
      end else begin
        m_ack[g] <= 1'b0;
        m_err[g] <= 1'b0;
        if (clr_left[g] > 0) clr_left[g] <= clr_left[g] - 1;
        if (clr_left[g] == 0 && !pend[g] && !m_ack[g] && req[g]) begin
          if (WS_T[g] == 0) begin
            complete(g, we[g], addr[g], wdata[g]);
          end else begin
            pend[g] <= 1'b1;
            rem[g]  <= WS_T[g];
            p_we[g] <= we[g];
            p_a[g]  <= addr[g];
            p_d[g]  <= wdata[g];
          end
        end else if (pend[g]) begin
          rem[g] <= rem[g] - 1;
          if (rem[g] == 1) begin
            pend[g] <= 1'b0;
            complete(g, p_we[g], p_a[g], p_d[g]);
          end
        end
      end
    end
  end

  // Per-cycle comparison; reset is level-gated because it clears the outputs asynchronously.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      check($sformatf("dut%0d ready", g), 32'(ready[g]), 32'(clr_left[g] == 0 && !rst[g]));
      check($sformatf("dut%0d ack", g), 32'(ack[g]), 32'(m_ack[g] && !rst[g]));
      if (m_ack[g] && !rst[g]) begin
        check($sformatf("dut%0d rdata", g), 32'(rdata[g]), 32'(m_rdata[g]));
`ifdef RAM_RANGE_CHK_EN
        check($sformatf("dut%0d err", g), 32'(err[g]), 32'(m_err[g]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int g, input logic w, input logic [9:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int lat);
    int n = 0;
    tick();
    req[g] = 1'b1; we[g] = w; addr[g] = a; wdata[g] = d;
    do begin
      tick();
      n++;
    end while (!ack[g] && n < LIMIT);
    if (n >= LIMIT) begin
      total++;
      bad++;
      $display("FAIL dut%0d ack timeout: waited %0d cycles without ack", g, n);
    end
    rd  = rdata[g];
`ifdef RAM_RANGE_CHK_EN
    er  = err[g];
`else
    er  = 1'b0;
`endif
    lat = n;
    req[g] = 1'b0; we[g] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat, n0, n1;

    for (int g = 0; g < N; g++) begin
      rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
    end
    repeat (3) tick();
    check("reset rdata", 32'(rdata[1]), 32'h0);
    check("reset ack", 32'(ack[1]), 32'h0);
    check("reset ready", 32'(ready[0]), 32'h0);
    for (int g = 0; g < N; g++) rst[g] = 1'b0;

    // Request raised during CLEAR is accepted on the first IDLE edge; ready rises after DEPTH cycles.
    fork
      begin
        access(0, 1'b0, 10'h001, 16'h0, rd, er, lat);
        check("clear-time req latency", 32'(lat), 32'd1024);
        check("clear-time read data", 32'(rd), 32'h0000);
      end
      begin
        n1 = 0;
        do begin
          tick();
          n1++;
        end while (!ready[1] && n1 < LIMIT);
        check("ready rise cycles", 32'(n1), 32'd1024);
      end
    join

    access(0, 1'b1, 10'h3FF, 16'hA5A5, rd, er, lat);
    check("ws0 write latency", 32'(lat), 32'd1);
    access(0, 1'b0, 10'h3FF, 16'h0, rd, er, lat);
    check("ws0 read latency", 32'(lat), 32'd1);
    check("ws0 read 3ff", 32'(rd), 32'hA5A5);
    access(0, 1'b0, 10'h001, 16'h0, rd, er, lat);
    check("ws0 read untouched", 32'(rd), 32'h0000);

    access(1, 1'b1, 10'h020, 16'hBEEF, rd, er, lat);
    check("ws3 write latency", 32'(lat), 32'd4);
    access(1, 1'b1, 10'h021, 16'h0C0C, rd, er, lat);

    // Read of 0x020 while addr/we/wdata change after acceptance.
    tick();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h020;
    tick();
    n0 = 1;
    addr[1] = 10'h021; we[1] = 1'b1; wdata[1] = 16'hFFFF;
    while (!ack[1] && n0 < LIMIT) begin
      tick();
      n0++;
    end
    check("ws3 latched read latency", 32'(n0), 32'd4);
    check("ws3 latched read data", 32'(rdata[1]), 32'hBEEF);
    req[1] = 1'b0; we[1] = 1'b0;
    access(1, 1'b0, 10'h021, 16'h0, rd, er, lat);
    check("ws3 memory unchanged", 32'(rd), 32'h0C0C);

    // req held across ack: repeat read of addr 5.
    access(1, 1'b1, 10'h005, 16'h5555, rd, er, lat);
    tick();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h005;
    n0 = 0;
    while (!ack[1] && n0 < LIMIT) begin
      tick();
      n0++;
    end
    rd = rdata[1];
    n1 = 0;
    do begin
      tick();
      n1++;
    end while (!ack[1] && n1 < LIMIT);
    req[1] = 1'b0;
    check("b2b ack spacing", 32'(n1), 32'd5);
    check("b2b first rdata", 32'(rd), 32'h5555);
    check("b2b second rdata", 32'(rdata[1]), 32'h5555);

    // Reset during WAIT of a write to addr 7.
    tick();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'h007; wdata[1] = 16'h1234;
    tick();
    tick();
    rst[1] = 1'b1; req[1] = 1'b0; we[1] = 1'b0;
    #1;
    check("abort ack low", 32'(ack[1]), 32'h0);
    check("abort ready low", 32'(ready[1]), 32'h0);
    repeat (2) tick();
    rst[1] = 1'b0;
    access(1, 1'b0, 10'h007, 16'h0, rd, er, lat);
    check("abort recheck latency", 32'(lat), 32'd1027);
    check("abort write discarded", 32'(rd), 32'h0000);

    // DEPTH=1000 instance: out-of-range and last valid address.
    access(2, 1'b1, 10'd1010, 16'hFFFF, rd, er, lat);
    check("oor write latency", 32'(lat), 32'd2);
`ifdef RAM_RANGE_CHK_EN
    check("oor write err", 32'(er), 32'h1);
`endif
    access(2, 1'b0, 10'd1010, 16'h0, rd, er, lat);
    check("oor read data", 32'(rd), 32'h0000);
`ifdef RAM_RANGE_CHK_EN
    check("oor read err", 32'(er), 32'h1);
`endif
    access(2, 1'b1, 10'd999, 16'h7777, rd, er, lat);
    access(2, 1'b0, 10'd999, 16'h0, rd, er, lat);
    check("last addr read data", 32'(rd), 32'h7777);
`ifdef RAM_RANGE_CHK_EN
    check("last addr err", 32'(er), 32'h0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
